// File: rtl/wb_stage_if.sv
// wb_stage_if: bundle between MEM, data memory response and the writeback stage
//   master modport (MEM/dmem/regfile side): drives in_*, dmem_*; observes in_ready and regfile write port
//   slave modport  (wb_stage side): receives in_*, dmem_*; drives in_ready, RegWrite, Rd, Write_data, load_err
interface wb_stage_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic            in_reg_write;
    logic [4:0]      in_rd;
    logic [1:0]      in_wb_sel;
    logic [2:0]      in_funct3;
    logic [1:0]      in_addr_lo;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_pc_plus4;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic            RegWrite;
    logic [4:0]      Rd;
    logic [XLEN-1:0] Write_data;
    logic            load_err;
    modport master (
        output in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_pc_plus4, dmem_rvalid, dmem_rdata,
        input  in_ready, RegWrite, Rd, Write_data, load_err
    );
    modport slave (
        input  in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_pc_plus4, dmem_rvalid, dmem_rdata,
        output in_ready, RegWrite, Rd, Write_data, load_err
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage; selects ALU/load/PC+4, waits for and aligns load data, drives regfile write
//   clk, rst_n (async active-low), bus (wb_stage_if.slave: MEM handshake, dmem response, regfile write port)
//   Optional WB_TIMEOUT_EN: abort a load with load_err after LOAD_TIMEOUT cycles without dmem_rvalid
module wb_stage #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input logic       clk,
    input logic       rst_n,
    wb_stage_if.slave bus
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;
    state_t          state_q, state_d;
    logic            lrw_q, lrw_d;
    logic [4:0]      lrd_q, lrd_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      a_q, a_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] ld_val;
    logic            ld_bad;
    logic            expire;
    assign byte_v = bus.dmem_rdata[8*a_q +: 8];
    assign half_v = bus.dmem_rdata[16*a_q[1] +: 16];
    // funct3[2] selects zero-extension, funct3[1:0] the access size
    assign ld_val = f3_q[1] ? bus.dmem_rdata :
                    f3_q[0] ? {{(XLEN-16){half_v[15] & ~f3_q[2]}}, half_v} :
                              {{(XLEN-8){byte_v[7] & ~f3_q[2]}}, byte_v};
    assign ld_bad = (f3_q[1:0] == 2'b11) || (f3_q[2] && f3_q[1]) ||
                    (f3_q[1:0] == 2'b01 && a_q[0]) || (f3_q[1:0] == 2'b10 && a_q != 2'b00);
`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(LOAD_TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    // held at zero in IDLE so it starts clean on every WAIT_LOAD entry
    assign cnt_d  = (state_q == IDLE || bus.dmem_rvalid) ? '0 : cnt_q + 1'b1;
    assign expire = (cnt_q == CW'(LOAD_TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic timeout_unused;
    assign timeout_unused = (LOAD_TIMEOUT == 0);
    assign expire = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        lrw_d       = lrw_q;
        lrd_d       = lrd_q;
        f3_d        = f3_q;
        a_d         = a_q;
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        err_d       = 1'b0;
        if (state_q == IDLE) begin
            if (bus.in_valid) begin
                if (bus.in_wb_sel == 2'b01) begin
                    state_d = WAIT_LOAD;
                    lrw_d   = bus.in_reg_write;
                    lrd_d   = bus.in_rd;
                    f3_d    = bus.in_funct3;
                    a_d     = bus.in_addr_lo;
                end else begin
                    reg_write_d = bus.in_reg_write && (bus.in_rd != 5'd0) && (bus.in_wb_sel != 2'b11);
                    rd_d        = bus.in_rd;
                    wdata_d     = (bus.in_wb_sel == 2'b10) ? bus.in_pc_plus4 : bus.in_alu_result;
                end
            end
        end else if (bus.dmem_rvalid) begin
            // rvalid beats the timeout when both land in the same cycle
            state_d     = IDLE;
            err_d       = ld_bad;
            reg_write_d = !ld_bad && lrw_q && (lrd_q != 5'd0);
            if (!ld_bad) begin
                rd_d    = lrd_q;
                wdata_d = ld_val;
            end
        end else if (expire) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lrw_q       <= 1'b0;
            lrd_q       <= '0;
            f3_q        <= '0;
            a_q         <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrw_q       <= lrw_d;
            lrd_q       <= lrd_d;
            f3_q        <= f3_d;
            a_q         <= a_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.RegWrite   = reg_write_q;
    assign bus.Rd         = rd_q;
    assign bus.Write_data = wdata_q;
    assign bus.load_err   = err_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed stimulus for wb_stage against a transaction-level model
module tb_wb_stage;
    localparam int LOAD_TIMEOUT = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    wb_stage_if #(.XLEN(32)) bus();
    wb_stage #(.XLEN(32), .LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int vectors = 0;
    int errors  = 0;
    logic check_en = 1'b0;
    logic busy;
    logic p_rw;
    logic [4:0] p_rd;
    logic [2:0] p_f3;
    logic [1:0] p_a;
    int wcnt;
    logic exp_ready, exp_rw, exp_err, exp_upd;
    logic [4:0] exp_rd;
    logic [31:0] exp_wd;
    logic nxt_rw, nxt_err, nxt_upd;
    logic [4:0] nxt_rd;
    logic [31:0] nxt_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // load result from the ISA rules: shift the word down, mask to size, extend numerically
    task automatic load_model(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] data,
                              output logic ok, output logic [31:0] v);
        logic [31:0] w;
        w = data >> (8 * a);
        ok = 1'b1;
        v = 32'd0;
        case (f3)
            3'd0: begin v = w & 32'hFF; if (v >= 128) v = v - 32'd256; end
            3'd4: v = w & 32'hFF;
            3'd1: begin ok = (a % 2 == 0); v = w & 32'hFFFF; if (v >= 32768) v = v - 32'd65536; end
            3'd5: begin ok = (a % 2 == 0); v = w & 32'hFFFF; end
            3'd2: begin ok = (a == 0); v = data; end
            default: ok = 1'b0;
        endcase
    endtask

    task automatic model_reset();
        busy = 1'b0; wcnt = 0;
        nxt_rw = 1'b0; nxt_err = 1'b0; nxt_upd = 1'b1; nxt_rd = 5'd0; nxt_wd = 32'd0;
        bus.in_valid = 1'b0; bus.in_reg_write = 1'b0; bus.in_rd = 5'd0; bus.in_wb_sel = 2'd0;
        bus.in_funct3 = 3'd0; bus.in_addr_lo = 2'd0; bus.in_alu_result = 32'd0; bus.in_pc_plus4 = 32'd0;
        bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
    endtask

    task automatic step(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [1:0] a, input logic [31:0] alu,
                        input logic [31:0] pc, input logic rv, input logic [31:0] rdat);
        logic ok;
        logic [31:0] val;
        @(posedge clk);
        #1;
        exp_ready = !busy; exp_rw = nxt_rw; exp_err = nxt_err; exp_upd = nxt_upd;
        exp_rd = nxt_rd; exp_wd = nxt_wd;
        bus.in_valid = v; bus.in_reg_write = rw; bus.in_rd = rd; bus.in_wb_sel = sel;
        bus.in_funct3 = f3; bus.in_addr_lo = a; bus.in_alu_result = alu; bus.in_pc_plus4 = pc;
        bus.dmem_rvalid = rv; bus.dmem_rdata = rdat;
        nxt_rw = 1'b0; nxt_err = 1'b0; nxt_upd = 1'b0;
        if (!busy) begin
            if (v) begin
                if (sel == 2'd1) begin
                    busy = 1'b1; p_rw = rw; p_rd = rd; p_f3 = f3; p_a = a; wcnt = 0;
                end else begin
                    nxt_rw = rw && rd != 0 && sel != 2'd3;
                    nxt_upd = (sel != 2'd3);
                    nxt_rd = rd;
                    nxt_wd = (sel == 2'd2) ? pc : alu;
                end
            end
        end else if (rv) begin
            load_model(p_f3, p_a, rdat, ok, val);
            busy = 1'b0;
            if (ok) begin
                nxt_rw = p_rw && p_rd != 0; nxt_upd = 1'b1; nxt_rd = p_rd; nxt_wd = val;
            end else nxt_err = 1'b1;
        end
`ifdef WB_TIMEOUT_EN
        else begin
            wcnt++;
            if (wcnt == LOAD_TIMEOUT) begin busy = 1'b0; nxt_err = 1'b1; end
        end
`endif
        check_en = 1'b1;
    endtask

    task automatic idle(input logic rv, input logic [31:0] rdat);
        step(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, rv, rdat);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
            chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, exp_rw});
            chk("load_err", {31'd0, bus.load_err}, {31'd0, exp_err});
            if (exp_upd) begin
                chk("Rd", {27'd0, bus.Rd}, {27'd0, exp_rd});
                chk("Write_data", bus.Write_data, exp_wd);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("rst_Rd", {27'd0, bus.Rd}, 32'd0);
        chk("rst_Write_data", bus.Write_data, 32'd0);
        chk("rst_load_err", {31'd0, bus.load_err}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        // ALU write
        step(1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h00001234, 32'd0, 0, 32'd0);
        idle(0, 32'd0);
        @(negedge clk);
        chk("alu_RegWrite", {31'd0, bus.RegWrite}, 32'd1);
        chk("alu_Rd", {27'd0, bus.Rd}, 32'd5);
        chk("alu_data", bus.Write_data, 32'h00001234);
        chk("alu_ready", {31'd0, bus.in_ready}, 32'd1);
        // LB, rvalid three cycles after acceptance
        step(1, 1, 5'd9, 2'd1, 3'd0, 2'd2, 32'd0, 32'd0, 0, 32'd0);
        idle(0, 32'd0);
        @(negedge clk);
        chk("lb_wait_ready", {31'd0, bus.in_ready}, 32'd0);
        idle(0, 32'd0);
        idle(1, 32'h12F45678);
        idle(0, 32'd0);
        @(negedge clk);
        chk("lb_RegWrite", {31'd0, bus.RegWrite}, 32'd1);
        chk("lb_data", bus.Write_data, 32'hFFFFFFF4);
        // LHU / LH at addr_lo=2
        step(1, 1, 5'd10, 2'd1, 3'd5, 2'd2, 32'd0, 32'd0, 0, 32'd0);
        idle(1, 32'h80010000);
        idle(0, 32'd0);
        @(negedge clk);
        chk("lhu_data", bus.Write_data, 32'h00008001);
        step(1, 1, 5'd11, 2'd1, 3'd1, 2'd2, 32'd0, 32'd0, 0, 32'd0);
        idle(1, 32'h80010000);
        idle(0, 32'd0);
        @(negedge clk);
        chk("lh_data", bus.Write_data, 32'hFFFF8001);
        // JAL writes PC+4
        step(1, 1, 5'd1, 2'd2, 3'd0, 2'd0, 32'h0000DEAD, 32'h00000104, 0, 32'd0);
        idle(0, 32'd0);
        @(negedge clk);
        chk("jal_data", bus.Write_data, 32'h00000104);
        // x0 write then back-to-back rd=7, rd=8
        step(1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h55, 32'd0, 0, 32'd0);
        step(1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h7, 32'd0, 0, 32'd0);
        @(negedge clk);
        chk("x0_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("x0_Rd", {27'd0, bus.Rd}, 32'd0);
        step(1, 1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h8, 32'd0, 0, 32'd0);
        @(negedge clk);
        chk("b2b_Rd7", {27'd0, bus.Rd}, 32'd7);
        chk("b2b_RegWrite7", {31'd0, bus.RegWrite}, 32'd1);
        idle(0, 32'd0);
        @(negedge clk);
        chk("b2b_Rd8", {27'd0, bus.Rd}, 32'd8);
        chk("b2b_RegWrite8", {31'd0, bus.RegWrite}, 32'd1);
        // misaligned LW
        step(1, 1, 5'd4, 2'd1, 3'd2, 2'd1, 32'd0, 32'd0, 0, 32'd0);
        idle(1, 32'hCAFEBABE);
        idle(0, 32'd0);
        @(negedge clk);
        chk("lw_mis_err", {31'd0, bus.load_err}, 32'd1);
        chk("lw_mis_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        idle(0, 32'd0);
        @(negedge clk);
        chk("lw_mis_err_clear", {31'd0, bus.load_err}, 32'd0);
`ifdef WB_TIMEOUT_EN
        step(1, 1, 5'd6, 2'd1, 3'd2, 2'd0, 32'd0, 32'd0, 0, 32'd0);
        repeat (LOAD_TIMEOUT) idle(0, 32'd0);
        idle(0, 32'd0);
        @(negedge clk);
        chk("timeout_err", {31'd0, bus.load_err}, 32'd1);
        chk("timeout_ready", {31'd0, bus.in_ready}, 32'd1);
`endif
        // reset in the middle of a load wait
        step(1, 1, 5'd12, 2'd1, 3'd2, 2'd0, 32'd0, 32'd0, 0, 32'd0);
        idle(0, 32'd0);
        @(posedge clk);
        #1;
        check_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("inrst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1, 32'h11223344);
        idle(0, 32'd0);
        @(negedge clk);
        chk("postrst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("postrst_Rd", {27'd0, bus.Rd}, 32'd0);
        chk("postrst_data", bus.Write_data, 32'd0);
        chk("postrst_err", {31'd0, bus.load_err}, 32'd0);
        chk("postrst_ready", {31'd0, bus.in_ready}, 32'd1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] sel;
            logic [2:0] f3;
            sel = ($urandom_range(0, 9) < 4) ? 2'd1 : 2'($urandom_range(0, 3));
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : ((($urandom_range(0, 4)) == 0) ? 3'd2 :
                 (($urandom_range(0, 1) == 0) ? {1'($urandom), 2'b00} : {1'($urandom), 2'b01}));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), sel, f3,
                 2'($urandom), $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom);
        end
        repeat (4) idle(1, 32'd0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
